// File: rtl/ucs_loader.sv
// Control-store loader: parses framed byte stream (A5, addr, count, words, XOR check),
// writes microwords into the control store and gates the micro-sequencer via cpu_hold.
module ucs_loader #(
    parameter int UW = 48,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          cs_we,
    output logic [AW-1:0] cs_addr,
    output logic [UW-1:0] cs_wdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int NB = UW / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR0, S_ADDR1, S_CNT0, S_CNT1, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t        state_q,    state_d;
    logic [7:0]    addr_h_q,   addr_h_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [7:0]    cnt_h_q,    cnt_h_d;
    logic [15:0]   wcnt_q,     wcnt_d;
    logic [BW-1:0] bcnt_q,     bcnt_d;
    logic [UW-1:0] word_q,     word_d;
    logic [7:0]    xor_q,      xor_d;
    logic          s_ready_q,  s_ready_d;
    logic          cs_we_q,    cs_we_d;
    logic [AW-1:0] cs_addr_q,  cs_addr_d;
    logic [UW-1:0] cs_wdata_q, cs_wdata_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic          err_q,      err_d;

    logic        acc;
    logic [15:0] cnt16;
    logic [15:0] addr16;

    assign acc    = s_valid && s_ready_q;
    assign cnt16  = {cnt_h_q, s_data};
    assign addr16 = {addr_h_q, s_data};

    always_comb begin
        state_d    = state_q;
        addr_h_d   = addr_h_q;
        addr_d     = addr_q;
        cnt_h_d    = cnt_h_q;
        wcnt_d     = wcnt_q;
        bcnt_d     = bcnt_q;
        word_d     = word_q;
        xor_d      = xor_q;
        cs_we_d    = 1'b0;
        cs_addr_d  = cs_addr_q;
        cs_wdata_d = cs_wdata_q;
        cpu_hold_d = cpu_hold_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (acc && s_data == 8'hA5) begin
                    state_d    = S_ADDR0;
                    cpu_hold_d = 1'b1;
                    busy_d     = 1'b1;
                    xor_d      = 8'h00;
                end
            end
            S_ADDR0: begin
                if (acc) begin
                    addr_h_d = s_data;
                    xor_d    = xor_q ^ s_data;
                    state_d  = S_ADDR1;
                end
            end
            S_ADDR1: begin
                if (acc) begin
                    addr_d  = AW'(addr16);
                    xor_d   = xor_q ^ s_data;
                    state_d = S_CNT0;
                end
            end
            S_CNT0: begin
                if (acc) begin
                    cnt_h_d = s_data;
                    xor_d   = xor_q ^ s_data;
                    state_d = S_CNT1;
                end
            end
            S_CNT1: begin
                if (acc) begin
                    xor_d  = xor_q ^ s_data;
                    wcnt_d = cnt16;
                    bcnt_d = '0;
                    // A count larger than the store itself cannot be a sane image
                    if (cnt16 == 16'd0 || 64'(cnt16) > (64'd1 << AW)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (acc) begin
                    xor_d  = xor_q ^ s_data;
                    word_d = (word_q << 8) | UW'(s_data);
                    if (bcnt_q == BW'(NB - 1)) begin
                        bcnt_d     = '0;
                        cs_we_d    = 1'b1;
                        cs_addr_d  = addr_q;
                        cs_wdata_d = word_d;
                        addr_d     = addr_q + 1'b1;
                        wcnt_d     = wcnt_q - 16'd1;
                        if (wcnt_q == 16'd1) state_d = S_CHK;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            S_CHK: begin
                if (acc) begin
                    busy_d = 1'b0;
                    if (s_data == xor_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        err_d      = 1'b0;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The terminal states swallow one cycle so the source sees the frame boundary
        s_ready_d = !(state_d == S_DONE || state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_h_q   <= '0;
            addr_q     <= '0;
            cnt_h_q    <= '0;
            wcnt_q     <= '0;
            bcnt_q     <= '0;
            word_q     <= '0;
            xor_q      <= '0;
            s_ready_q  <= 1'b1;
            cs_we_q    <= 1'b0;
            cs_addr_q  <= '0;
            cs_wdata_q <= '0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_h_q   <= addr_h_d;
            addr_q     <= addr_d;
            cnt_h_q    <= cnt_h_d;
            wcnt_q     <= wcnt_d;
            bcnt_q     <= bcnt_d;
            word_q     <= word_d;
            xor_q      <= xor_d;
            s_ready_q  <= s_ready_d;
            cs_we_q    <= cs_we_d;
            cs_addr_q  <= cs_addr_d;
            cs_wdata_q <= cs_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign cs_we    = cs_we_q;
    assign cs_addr  = cs_addr_q;
    assign cs_wdata = cs_wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
